// File: rtl/data_cache_sa_pkg.sv
// Shared types and width helpers for the set-associative data cache.
package data_cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    RESPOND   = 3'd4
  } state_e;

  // Offset field width: selects a word within a line.
  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  // Index field width: selects a set.
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag field width: whatever remains above index and offset.
  function automatic int tag_w(input int aw, input int sets, input int words);
    return aw - $clog2(sets) - $clog2(words);
  endfunction

  // LRU age width; kept at one bit for a direct-mapped build so vectors stay legal.
  function automatic int age_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/data_cache_sa_if.sv
// Backing-memory word-transfer bus: the cache is master, the memory is slave.
interface data_cache_sa_if
  import data_cache_pkg::*;
#(
  parameter int AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/data_cache_sa_lru.sv
// Combinational LRU helper for one set: next age vector and replacement victim.
module cache_lru
  import data_cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0][AGE_W-1:0] age_i,
  input  logic [WAYS-1:0]            valid_i,
  input  logic [WAY_W-1:0]           way_i,
  input  logic                       fill_i,
  output logic [WAYS-1:0][AGE_W-1:0] age_o,
  output logic [WAY_W-1:0]           victim_o
);
  localparam logic [AGE_W-1:0] OLDEST = AGE_W'(WAYS - 1);

  logic [AGE_W-1:0] old_age_s;

  // A freshly filled way counts as the oldest, so every other way ages past it.
  always_comb begin
    old_age_s = OLDEST;
    if (fill_i) begin
      old_age_s = OLDEST;
    end else begin
      old_age_s = age_i[way_i];
    end
  end

  // Accessed way becomes youngest; ways younger than it move one step older.
  always_comb begin
    age_o = age_i;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == way_i) begin
        age_o[w] = {AGE_W{1'b0}};
      end else if (age_i[w] < old_age_s) begin
        age_o[w] = age_i[w] + AGE_W'(1);
      end else begin
        age_o[w] = age_i[w];
      end
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the oldest way.
  always_comb begin
    victim_o = {WAY_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      if (age_i[w] == OLDEST) begin
        victim_o = WAY_W'(w);
      end else begin
        victim_o = victim_o;
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o = WAY_W'(w);
      end else begin
        victim_o = victim_o;
      end
    end
  end
endmodule

// File: rtl/data_cache_sa.sv
// Set-associative write-back/write-allocate data cache with LRU replacement.
module data_cache_sa
  import data_cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int WORDS = 4,
  parameter int AW    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [AW-1:0]   addr,
  input  logic [31:0]     write_data,
  input  logic            memwrite,
  output logic [31:0]     read_data,
  output logic            read_finished,
  output logic            write_finished,
  output logic            busy,
  data_cache_sa_if.master mem
);
  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(AW, SETS, WORDS);
  localparam int AGE_W = age_w(WAYS);
  localparam int WAY_W = AGE_W;

  state_e state_q, state_d;
  logic   busy_q;

  logic [TAG_W-1:0] req_tag_q;
  logic [IDX_W-1:0] req_idx_q;
  logic [OFF_W-1:0] req_off_q;
  logic [31:0]      req_wdata_q;
  logic             req_we_q;

  logic [WAYS-1:0]            valid_q [SETS];
  logic [WAYS-1:0]            dirty_q [SETS];
  logic [TAG_W-1:0]           tag_q   [SETS][WAYS];
  logic [31:0]                data_q  [SETS][WAYS][WORDS];
  logic [WAYS-1:0][AGE_W-1:0] age_q   [SETS];

  logic [WAY_W-1:0] victim_q;
  logic [OFF_W-1:0] cnt_q;
  logic [31:0]      read_data_q;
  logic             read_finished_q, write_finished_q;
  logic             mem_req_q, mem_we_q;
  logic [AW-1:0]    mem_addr_q;
  logic [31:0]      mem_wdata_q;

  logic                       hit_s, do_acc_s, xfer_s, last_s, victim_dirty_s;
  logic [WAY_W-1:0]           hit_way_s, acc_way_s, victim_s;
  logic [WAYS-1:0][AGE_W-1:0] age_next_s;

  assign xfer_s         = mem_req_q && mem.mem_ack;
  assign last_s         = (cnt_q == OFF_W'(WORDS - 1));
  assign victim_dirty_s = valid_q[req_idx_q][victim_s] && dirty_q[req_idx_q][victim_s];

  // Tag compare across every way of the latched set.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = {WAY_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
        hit_s     = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // The processor access happens on a LOOKUP hit or in RESPOND after a fill.
  always_comb begin
    do_acc_s  = 1'b0;
    acc_way_s = victim_q;
    if (state_q == LOOKUP) begin
      do_acc_s  = hit_s;
      acc_way_s = hit_way_s;
    end else if (state_q == RESPOND) begin
      do_acc_s  = 1'b1;
      acc_way_s = victim_q;
    end else begin
      do_acc_s  = 1'b0;
    end
  end

  cache_lru #(.WAYS(WAYS), .AGE_W(AGE_W), .WAY_W(WAY_W)) u_lru (
    .age_i    (age_q[req_idx_q]),
    .valid_i  (valid_q[req_idx_q]),
    .way_i    (acc_way_s),
    .fill_i   (state_q == RESPOND),
    .age_o    (age_next_s),
    .victim_o (victim_s)
  );

  // Next-state logic for the request sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = LOOKUP;
        else        state_d = IDLE;
      end
      LOOKUP: begin
        if (hit_s)               state_d = IDLE;
        else if (victim_dirty_s) state_d = WRITEBACK;
        else                     state_d = REFILL;
      end
      WRITEBACK: begin
        if (xfer_s && last_s) state_d = REFILL;
        else                  state_d = WRITEBACK;
      end
      REFILL: begin
        if (xfer_s && last_s) state_d = RESPOND;
        else                  state_d = REFILL;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Request latch, arrays, memory bus and processor result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q      <= 32'd0;
      read_finished_q  <= 1'b0;
      write_finished_q <= 1'b0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= {AW{1'b0}};
      mem_wdata_q      <= 32'd0;
      cnt_q            <= {OFF_W{1'b0}};
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= {WAYS{1'b0}};
        dirty_q[s] <= {WAYS{1'b0}};
        age_q[s]   <= {(WAYS*AGE_W){1'b0}};
      end
    end else begin
      read_finished_q  <= 1'b0;
      write_finished_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            req_tag_q   <= addr[AW-1 -: TAG_W];
            req_idx_q   <= addr[OFF_W +: IDX_W];
            req_off_q   <= addr[OFF_W-1:0];
            req_wdata_q <= write_data;
            req_we_q    <= memwrite;
          end
        end
        LOOKUP: begin
          victim_q <= victim_s;
          cnt_q    <= {OFF_W{1'b0}};
          if (!hit_s) begin
            mem_req_q <= 1'b1;
            if (victim_dirty_s) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[req_idx_q][victim_s], req_idx_q, {OFF_W{1'b0}}};
              mem_wdata_q <= data_q[req_idx_q][victim_s][0];
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (xfer_s) begin
            cnt_q <= cnt_q + OFF_W'(1);
            if (last_s) begin
              // Refill burst follows the writeback burst with no idle gap.
              mem_we_q   <= 1'b0;
              mem_addr_q <= {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            end else begin
              mem_addr_q  <= mem_addr_q + AW'(1);
              mem_wdata_q <= data_q[req_idx_q][victim_q][cnt_q + OFF_W'(1)];
            end
          end
        end
        REFILL: begin
          if (xfer_s) begin
            data_q[req_idx_q][victim_q][cnt_q] <= mem.mem_rdata;
            cnt_q <= cnt_q + OFF_W'(1);
            if (last_s) begin
              mem_req_q                    <= 1'b0;
              valid_q[req_idx_q][victim_q] <= 1'b1;
              dirty_q[req_idx_q][victim_q] <= 1'b0;
              tag_q[req_idx_q][victim_q]   <= req_tag_q;
            end else begin
              mem_addr_q <= mem_addr_q + AW'(1);
            end
          end
        end
        RESPOND: begin
        end
        default: begin
        end
      endcase
      if (do_acc_s) begin
        age_q[req_idx_q] <= age_next_s;
        if (req_we_q) begin
          data_q[req_idx_q][acc_way_s][req_off_q] <= req_wdata_q;
          dirty_q[req_idx_q][acc_way_s]           <= 1'b1;
          write_finished_q                        <= 1'b1;
        end else begin
          read_data_q     <= data_q[req_idx_q][acc_way_s][req_off_q];
          read_finished_q <= 1'b1;
        end
      end
    end
  end

  assign read_data      = read_data_q;
  assign read_finished  = read_finished_q;
  assign write_finished = write_finished_q;
  assign busy           = busy_q;
  assign mem.mem_req    = mem_req_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_data_cache_sa.sv
// Directed plus random bench for data_cache_sa against a line/recency reference model.
module tb_data_cache_sa;
  localparam int WAYS = 2, SETS = 8, WORDS = 4, AW = 32, MEMSZ = 256;

  logic          clk = 1'b0;
  logic          reset, enable, memwrite;
  logic [AW-1:0] addr;
  logic [31:0]   write_data, read_data;
  logic          read_finished, write_finished, busy;

  data_cache_sa_if #(.AW(AW)) mif ();

  data_cache_sa #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr),
    .write_data(write_data), .memwrite(memwrite), .read_data(read_data),
    .read_finished(read_finished), .write_finished(write_finished),
    .busy(busy), .mem(mif)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; int a; logic [31:0] d; } xfer_t;
  xfer_t       log_q[$];
  xfer_t       exp_q[$];
  logic [31:0] mem  [MEMSZ];
  logic [31:0] emem [MEMSZ];
  int          n_pass, n_total;

  // Reference model: whole lines per set plus a most-recent-first way list.
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  int          m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][WORDS];
  int          rec     [SETS][$];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      rec[s].delete();
    end
    last_rd = 32'd0;
  endtask

  task automatic model_req(input int a, input bit we, input logic [31:0] wd,
                           output bit hit, output logic [31:0] rexp);
    int off, s, t, w, ba;
    off = a % WORDS;
    s   = (a / WORDS) % SETS;
    t   = a / (WORDS * SETS);
    w   = -1;
    for (int i = 0; i < WAYS; i++)
      if (m_valid[s][i] && m_tag[s][i] == t) w = i;
    hit = (w >= 0);
    if (!hit) begin
      for (int i = WAYS - 1; i >= 0; i--)
        if (!m_valid[s][i]) w = i;
      if (w < 0) w = rec[s][rec[s].size() - 1];
      if (m_valid[s][w] && m_dirty[s][w]) begin
        for (int j = 0; j < WORDS; j++) begin
          ba = (m_tag[s][w] * SETS + s) * WORDS + j;
          exp_q.push_back('{1'b1, ba, m_data[s][w][j]});
          emem[ba] = m_data[s][w][j];
        end
      end
      for (int j = 0; j < WORDS; j++) begin
        ba = (t * SETS + s) * WORDS + j;
        exp_q.push_back('{1'b0, ba, emem[ba]});
        m_data[s][w][j] = emem[ba];
      end
      m_valid[s][w] = 1'b1;
      m_dirty[s][w] = 1'b0;
      m_tag[s][w]   = t;
    end
    if (we) begin
      m_data[s][w][off] = wd;
      m_dirty[s][w]     = 1'b1;
    end else begin
      last_rd = m_data[s][w][off];
    end
    rexp = last_rd;
    for (int i = 0; i < rec[s].size(); i++)
      if (rec[s][i] == w) begin
        rec[s].delete(i);
        break;
      end
    rec[s].push_front(w);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd"}, 64'(read_data), 64'd0);
    check({tag, "_pulses"}, 64'({read_finished, write_finished}), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_req"}, 64'({mif.mem_req, mif.mem_we}), 64'd0);
    check({tag, "_maddr"}, 64'(mif.mem_addr), 64'd0);
    check({tag, "_mwdata"}, 64'(mif.mem_wdata), 64'd0);
  endtask

  // One request from acceptance to finished pulse; called on a falling edge.
  task automatic do_req(input int a, input bit we, input logic [31:0] wd, input bit poke,
                        output logic [31:0] rd, output int lat);
    bit hit, done;
    logic [31:0] rexp;
    model_req(a, we, wd, hit, rexp);
    enable = 1'b1; addr = AW'(a); write_data = wd; memwrite = we;
    @(negedge clk);
    enable = 1'b0; addr = $urandom; write_data = $urandom; memwrite = 1'($urandom_range(0, 1));
    check("accept_busy", 64'(busy), 64'd1);
    check("accept_quiet", 64'({read_finished, write_finished}), 64'd0);
    lat = 1; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      enable = poke && (c == 2);
      @(posedge clk);
      lat++;
      @(negedge clk);
      done = read_finished || write_finished;
    end
    enable = 1'b0;
    if (!done) begin
      check("timeout", 64'd0, 64'd1);
    end else begin
      check("pulse_kind", 64'({read_finished, write_finished}), we ? 64'd1 : 64'd2);
      check("done_busy", 64'(busy), 64'd0);
      check("read_data", 64'(read_data), 64'(rexp));
      if (hit) check("hit_latency", 64'(lat), 64'd2);
      else     check("miss_latency_min", 64'(lat >= 2 + WORDS + 1), 64'd1);
    end
    check("xfer_count", 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("xfer%0d_we", i), 64'(log_q[i].we), 64'(exp_q[i].we));
      check($sformatf("xfer%0d_addr", i), 64'(log_q[i].a), 64'(exp_q[i].a));
      check($sformatf("xfer%0d_data", i), 64'(log_q[i].d), 64'(exp_q[i].d));
    end
    log_q.delete();
    exp_q.delete();
    rd = read_data;
  endtask

  // Memory responder: random 0-5 cycle ack delay, transfer log, request hold check.
  initial begin
    int          wait_cnt;
    bit          pend, hold;
    xfer_t       pend_x;
    logic [31:0] h_a, h_wd;
    logic        h_we;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;
    wait_cnt = 0; pend = 1'b0; hold = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (pend) begin
        if (pend_x.we) mem[pend_x.a % MEMSZ] = pend_x.d;
        log_q.push_back(pend_x);
        wait_cnt = $urandom_range(0, 5);
      end
      if (hold) begin
        check("hold_req", 64'(mif.mem_req), 64'd1);
        check("hold_bus", 64'({mif.mem_we, mif.mem_addr, mif.mem_wdata}), 64'({h_we, h_a, h_wd}));
      end
      if (mif.mem_req && wait_cnt == 0) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = mem[int'(mif.mem_addr) % MEMSZ];
      end else begin
        mif.mem_ack = 1'b0;
        if (mif.mem_req && wait_cnt > 0) wait_cnt--;
      end
      pend   = mif.mem_req && mif.mem_ack && !reset;
      pend_x = '{mif.mem_we, int'(mif.mem_addr), mif.mem_we ? mif.mem_wdata : mif.mem_rdata};
      hold   = mif.mem_req && !mif.mem_ack && !reset;
      h_a = mif.mem_addr; h_wd = mif.mem_wdata; h_we = mif.mem_we;
    end
  end

  // Directed test-plan sequence, mid-burst reset, then random traffic.
  initial begin
    logic [31:0] rd;
    int          lat, a;
    bit          found;
    n_pass = 0; n_total = 0;
    reset = 1'b1; enable = 1'b0; addr = '0; write_data = 32'd0; memwrite = 1'b0;
    for (int i = 0; i < MEMSZ; i++) begin
      mem[i]  = 32'(i + 100);
      emem[i] = 32'(i + 100);
    end
    model_reset();
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    do_req(1, 1'b0, 32'd0, 1'b0, rd, lat);
    check("tp_load1", 64'(rd), 64'd101);
    do_req(1, 1'b1, 32'd7, 1'b0, rd, lat);
    do_req(1, 1'b0, 32'd0, 1'b0, rd, lat);
    check("tp_load1_after_store", 64'(rd), 64'd7);
    do_req(32, 1'b1, 32'd3, 1'b0, rd, lat);
    do_req(1, 1'b0, 32'd0, 1'b0, rd, lat);
    check("tp_load1_still", 64'(rd), 64'd7);
    do_req(64, 1'b0, 32'd0, 1'b1, rd, lat);
    check("tp_load64", 64'(rd), 64'd164);
    @(negedge clk);
    check("poke_no_accept", 64'({busy, read_finished, write_finished, mif.mem_req}), 64'd0);
    do_req(1, 1'b0, 32'd0, 1'b0, rd, lat);
    check("tp_load1_hit", 64'(rd), 64'd7);

    // Reset while the third refill word of a miss is outstanding.
    enable = 1'b1; addr = AW'(160); memwrite = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      found = (log_q.size() == 2);
    end
    check("midburst_reached", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_idle("midburst_reset");
    reset = 1'b0;
    model_reset();
    log_q.delete();
    do_req(1, 1'b0, 32'd0, 1'b0, rd, lat);
    check("after_reset_load1", 64'(rd), 64'd101);
    check("after_reset_miss", 64'(lat > 2), 64'd1);

    repeat (80) begin
      a = $urandom_range(0, MEMSZ - 1);
      do_req(a, 1'($urandom_range(0, 1)), $urandom, 1'b0, rd, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
